// File: rtl/pixel_stream_engine.sv
// Frame streamer: reads one frame from a synchronous frame RAM, frames it with VSYNC/HSYNC,
// applies a runtime-selected point operation and emits PPC pixels per beat on valid/ready.
module pixel_stream_engine #(
    parameter int WIDTH          = 956,
    parameter int HEIGHT         = 635,
    parameter int PPC            = 2,
    parameter int DW             = 8,
    parameter int START_UP_DELAY = 100,
    parameter int HSYNC_DELAY    = 160,
    parameter int BOTTOM_UP      = 1,
    parameter int AW             = 20
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  start,
    input  logic [2:0]            mode,
    input  logic [DW-1:0]         value,
    input  logic                  sign,
    input  logic [DW-1:0]         threshold,
    output logic                  mem_rd,
    output logic [AW-1:0]         mem_addr,
    input  logic [3*PPC*DW-1:0]   mem_rdata,
    output logic                  VSYNC,
    output logic                  HSYNC,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PPC*DW-1:0]     DATA_R,
    output logic [PPC*DW-1:0]     DATA_G,
    output logic [PPC*DW-1:0]     DATA_B,
    output logic                  busy,
    output logic                  ctrl_done
);

    localparam int WPR  = WIDTH / PPC;
    localparam int CW   = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int DMAX = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
    localparam int DCW  = (DMAX > 1) ? $clog2(DMAX) : 1;
    localparam int XW   = DW + 2;
    localparam int BW   = PPC * DW;

    localparam logic [CW-1:0]  LAST_COL   = CW'(WPR - 1);
    localparam logic [RW-1:0]  LAST_ROW   = RW'(HEIGHT - 1);
    localparam logic [DCW-1:0] VS_LAST    = DCW'(START_UP_DELAY - 1);
    localparam logic [DCW-1:0] HS_LAST    = DCW'(HSYNC_DELAY - 1);
    localparam logic [AW-1:0]  FIRST_ADDR = (BOTTOM_UP != 0) ? AW'((HEIGHT - 1) * WPR) : '0;
    localparam logic [AW-1:0]  ROW_BACK   = AW'(2 * WPR - 1);
    localparam logic [XW-1:0]  MAXV       = XW'((1 << DW) - 1);
    localparam logic [XW-1:0]  THREE      = XW'(3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_HSYNC,
        S_DATA,
        S_DONE
    } state_t;

    state_t         state;
    logic [DCW-1:0] dcnt;
    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic [AW-1:0]  addr;
    logic           rd_d;
    logic [1:0]     occ;
    logic           wr_ptr;
    logic           rd_ptr;
    logic [BW-1:0]  fifo_r [2];
    logic [BW-1:0]  fifo_g [2];
    logic [BW-1:0]  fifo_b [2];
    logic [2:0]     mode_q;
    logic [DW-1:0]  value_q;
    logic           sign_q;
    logic [DW-1:0]  thr_q;

    logic           pop;
    logic [2:0]     pend;
    logic           accept_start;
    logic [BW-1:0]  proc_r;
    logic [BW-1:0]  proc_g;
    logic [BW-1:0]  proc_b;

    function automatic logic [DW-1:0] bright(input logic [DW-1:0] x, input logic [DW-1:0] v,
                                             input logic sg);
        logic [XW-1:0] t;
        t = {2'b00, x} + {2'b00, v};
        if (sg)
            return (t > MAXV) ? '1 : DW'(t);
        else
            return (x < v) ? '0 : x - v;
    endfunction

    // Returns {B,G,R} for one pixel.
    function automatic logic [3*DW-1:0] point_op(input logic [2:0] md, input logic [DW-1:0] r,
                                                 input logic [DW-1:0] g, input logic [DW-1:0] b,
                                                 input logic [DW-1:0] val, input logic sg,
                                                 input logic [DW-1:0] thr);
        logic [XW-1:0] s;
        logic [XW-1:0] q;
        logic [DW-1:0] y;
        logic [DW-1:0] t;
        s = {2'b00, r} + {2'b00, g} + {2'b00, b};
        q = s / THREE;
        y = DW'(q);
        t = (q > {2'b00, thr}) ? '1 : '0;
        case (md)
            3'd1:    return {bright(b, val, sg), bright(g, val, sg), bright(r, val, sg)};
            3'd2:    return {~b, ~g, ~r};
            3'd3:    return {y, y, y};
            3'd4:    return {t, t, t};
            default: return {b, g, r};
        endcase
    endfunction

    always_comb begin
        proc_r = '0;
        proc_g = '0;
        proc_b = '0;
        for (int unsigned p = 0; p < PPC; p++) begin
            logic [3*DW-1:0] px;
            logic [3*DW-1:0] res;
            px  = mem_rdata[3*DW*p +: 3*DW];
            res = point_op(mode_q, px[DW-1:0], px[2*DW-1:DW], px[3*DW-1:2*DW],
                           value_q, sign_q, thr_q);
            proc_r[DW*p +: DW] = res[DW-1:0];
            proc_g[DW*p +: DW] = res[2*DW-1:DW];
            proc_b[DW*p +: DW] = res[3*DW-1:2*DW];
        end
    end

    assign out_valid    = (occ != 2'd0);
    assign HSYNC        = out_valid;
    assign VSYNC        = (state == S_VSYNC);
    assign pop          = out_valid && out_ready;
    assign DATA_R       = fifo_r[rd_ptr];
    assign DATA_G       = fifo_g[rd_ptr];
    assign DATA_B       = fifo_b[rd_ptr];
    assign mem_addr     = addr;
    assign accept_start = start && ((state == S_IDLE) || ((state == S_DONE) && !busy));

    // Reads still travelling through the RAM count against the FIFO, so a read is only issued
    // when the buffered plus in-flight beats leave room, counting a pop in the same cycle.
    assign pend   = {1'b0, occ} + {2'b00, rd_d};
    assign mem_rd = (state == S_DATA) && ((pend < 3'd2) || ((pend == 3'd2) && pop));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= S_IDLE;
            dcnt      <= '0;
            col       <= '0;
            row       <= '0;
            addr      <= '0;
            rd_d      <= 1'b0;
            occ       <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            fifo_r    <= '{default: '0};
            fifo_g    <= '{default: '0};
            fifo_b    <= '{default: '0};
            mode_q    <= '0;
            value_q   <= '0;
            sign_q    <= 1'b0;
            thr_q     <= '0;
            busy      <= 1'b0;
            ctrl_done <= 1'b0;
        end else begin
            rd_d <= mem_rd;
            occ  <= occ + {1'b0, rd_d} - {1'b0, pop};
            if (rd_d) begin
                fifo_r[wr_ptr] <= proc_r;
                fifo_g[wr_ptr] <= proc_g;
                fifo_b[wr_ptr] <= proc_b;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;

            if (accept_start) begin
                state     <= S_VSYNC;
                dcnt      <= '0;
                row       <= '0;
                col       <= '0;
                addr      <= FIRST_ADDR;
                mode_q    <= mode;
                value_q   <= value;
                sign_q    <= sign;
                thr_q     <= threshold;
                busy      <= 1'b1;
                ctrl_done <= 1'b0;
            end else begin
                case (state)
                    S_VSYNC: begin
                        if (dcnt == VS_LAST) begin
                            state <= S_HSYNC;
                            dcnt  <= '0;
                        end else begin
                            dcnt <= dcnt + 1'b1;
                        end
                    end
                    S_HSYNC: begin
                        if (dcnt == HS_LAST) begin
                            state <= S_DATA;
                            dcnt  <= '0;
                            col   <= '0;
                        end else begin
                            dcnt <= dcnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (mem_rd) begin
                            if (col == LAST_COL) begin
                                col <= '0;
                                if (row == LAST_ROW) begin
                                    state <= S_DONE;
                                end else begin
                                    row   <= row + 1'b1;
                                    state <= S_HSYNC;
                                    dcnt  <= '0;
                                    addr  <= (BOTTOM_UP != 0) ? addr - ROW_BACK : addr + 1'b1;
                                end
                            end else begin
                                col  <= col + 1'b1;
                                addr <= addr + 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        if (busy && !rd_d && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
                            busy      <= 1'b0;
                            ctrl_done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixel_stream_engine.sv
// Directed bench for pixel_stream_engine on a 4x2 frame, 2 pixels per beat, bottom-up readout.
module tb_pixel_stream_engine;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int P   = 2;
    localparam int D   = 8;
    localparam int SUD = 100;
    localparam int HSD = 5;
    localparam int AWB = 4;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        start;
    logic [2:0]  mode;
    logic [7:0]  value;
    logic        sign;
    logic [7:0]  threshold;
    logic        mem_rd;
    logic [3:0]  mem_addr;
    logic [47:0] mem_rdata = '0;
    logic        VSYNC;
    logic        HSYNC;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] DATA_R;
    logic [15:0] DATA_G;
    logic [15:0] DATA_B;
    logic        busy;
    logic        ctrl_done;

    int          nchk = 0;
    int          nfail = 0;
    logic [47:0] ram [0:15];
    logic [47:0] e [0:3];
    int          addr_order [4] = '{2, 3, 0, 1};

    pixel_stream_engine #(
        .WIDTH(W), .HEIGHT(H), .PPC(P), .DW(D), .START_UP_DELAY(SUD),
        .HSYNC_DELAY(HSD), .BOTTOM_UP(1), .AW(AWB)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .mode(mode), .value(value),
        .sign(sign), .threshold(threshold), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .VSYNC(VSYNC), .HSYNC(HSYNC), .out_valid(out_valid),
        .out_ready(out_ready), .DATA_R(DATA_R), .DATA_G(DATA_G), .DATA_B(DATA_B),
        .busy(busy), .ctrl_done(ctrl_done)
    );

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) if (mem_rd) mem_rdata <= ram[mem_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] wd(input logic [7:0] r0, input logic [7:0] g0, input logic [7:0] b0,
                                       input logic [7:0] r1, input logic [7:0] g1, input logic [7:0] b1);
        return {b1, g1, r1, b0, g0, r0};
    endfunction

    // Expected word (pixel {B,G,R}) regrouped as {DATA_R, DATA_G, DATA_B}.
    function automatic logic [47:0] expbus(input logic [47:0] w);
        return {w[31:24], w[7:0], w[39:32], w[15:8], w[47:40], w[23:16]};
    endfunction

    task automatic run_frame(input string tag, input logic [2:0] md, input logic [7:0] val,
                             input logic sg, input logic [7:0] thr, input bit stall, input bit inject);
        int nrd, nacc, vs, maxo, lastacc, donecyc;
        bit held, fin, hs_bad, injected;
        logic [47:0] hdat;
        nrd = 0; nacc = 0; vs = 0; maxo = 0; lastacc = -10; donecyc = -1;
        held = 0; fin = 0; hs_bad = 0; injected = 0; hdat = '0;
        @(negedge HCLK);
        start = 1'b1; mode = md; value = val; sign = sg; threshold = thr; out_ready = 1'b1;
        @(negedge HCLK);
        start = 1'b0; mode = 3'd2; value = 8'd7; sign = ~sg; threshold = 8'd0;
        #1;
        chk($sformatf("%s busy_after_start", tag), busy, 1);
        chk($sformatf("%s done_after_start", tag), ctrl_done, 0);
        if (VSYNC) vs++;
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            @(negedge HCLK);
            out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (inject) begin
                start = (nacc == 1) && !injected;
                if (start) injected = 1;
            end
            #1;
            if (VSYNC) vs++;
            if (HSYNC !== out_valid) hs_bad = 1;
            if (mem_rd) begin
                if (nrd < 4) chk($sformatf("%s addr%0d", tag, nrd), mem_addr, addr_order[nrd]);
                nrd++;
            end
            if (held) begin
                chk($sformatf("%s hold_valid", tag), out_valid, 1);
                chk($sformatf("%s hold_data", tag), {DATA_R, DATA_G, DATA_B}, hdat);
            end
            if (out_valid && out_ready) begin
                if (nacc < 4)
                    chk($sformatf("%s beat%0d", tag, nacc), {DATA_R, DATA_G, DATA_B},
                        expbus(e[addr_order[nacc]]));
                nacc++;
                lastacc = cyc;
            end
            if (nrd - nacc > maxo) maxo = nrd - nacc;
            held = out_valid && !out_ready;
            hdat = {DATA_R, DATA_G, DATA_B};
            if (ctrl_done) begin
                fin = 1;
                donecyc = cyc;
                chk($sformatf("%s busy_at_done", tag), busy, 0);
            end
        end
        start = 1'b0;
        chk($sformatf("%s done_seen", tag), fin, 1);
        chk($sformatf("%s done_latency", tag), donecyc - lastacc, 1);
        chk($sformatf("%s vsync_cycles", tag), vs, SUD);
        chk($sformatf("%s reads", tag), nrd, 4);
        chk($sformatf("%s beats", tag), nacc, 4);
        chk($sformatf("%s hsync_eq_valid", tag), hs_bad, 0);
        chk($sformatf("%s outstanding_le2", tag), maxo <= 2, 1);
    endtask

    initial begin
        bit found;
        int stray;
        for (int i = 0; i < 16; i++) ram[i] = '0;
        ram[0] = wd(230, 10, 0, 30, 200, 255);
        ram[1] = wd(10, 20, 31, 90, 90, 90);
        ram[2] = wd(91, 91, 92, 0, 128, 255);
        ram[3] = wd(1, 2, 3, 100, 50, 200);

        HRESETn = 1'b0; start = 1'b0; mode = '0; value = '0; sign = 1'b0;
        threshold = '0; out_ready = 1'b1;
        #12;
        chk("reset outputs", {VSYNC, HSYNC, out_valid, mem_rd, busy, ctrl_done}, 0);
        chk("reset data", {DATA_R, DATA_G, DATA_B}, 0);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // T1 bypass
        for (int i = 0; i < 4; i++) e[i] = ram[i];
        run_frame("T1", 3'd0, 8'd0, 1'b0, 8'd0, 0, 0);
        repeat (3) @(negedge HCLK);
        #1;
        chk("T1 done_held", ctrl_done, 1);

        // T2 brightness
        e[0] = wd(255, 60, 50, 80, 250, 255);
        e[1] = wd(60, 70, 81, 140, 140, 140);
        e[2] = wd(141, 141, 142, 50, 178, 255);
        e[3] = wd(51, 52, 53, 150, 100, 250);
        run_frame("T2add", 3'd1, 8'd50, 1'b1, 8'd0, 0, 0);
        e[0] = wd(180, 0, 0, 0, 150, 205);
        e[1] = wd(0, 0, 0, 40, 40, 40);
        e[2] = wd(41, 41, 42, 0, 78, 205);
        e[3] = wd(0, 0, 0, 50, 0, 150);
        run_frame("T2sub", 3'd1, 8'd50, 1'b0, 8'd0, 0, 0);

        // invert
        e[0] = wd(25, 245, 255, 225, 55, 0);
        e[1] = wd(245, 235, 224, 165, 165, 165);
        e[2] = wd(164, 164, 163, 255, 127, 0);
        e[3] = wd(254, 253, 252, 155, 205, 55);
        run_frame("INV", 3'd2, 8'd0, 1'b0, 8'd0, 0, 0);

        // T3 grayscale and threshold
        e[0] = wd(80, 80, 80, 161, 161, 161);
        e[1] = wd(20, 20, 20, 90, 90, 90);
        e[2] = wd(91, 91, 91, 127, 127, 127);
        e[3] = wd(2, 2, 2, 116, 116, 116);
        run_frame("T3gray", 3'd3, 8'd0, 1'b0, 8'd0, 0, 0);
        e[0] = wd(0, 0, 0, 255, 255, 255);
        e[1] = wd(0, 0, 0, 0, 0, 0);
        e[2] = wd(255, 255, 255, 255, 255, 255);
        e[3] = wd(0, 0, 0, 255, 255, 255);
        run_frame("T3thr", 3'd4, 8'd0, 1'b0, 8'd90, 0, 0);

        // T4 stalls, T6 start ignored mid-frame
        for (int i = 0; i < 4; i++) e[i] = ram[i];
        run_frame("T4", 3'd0, 8'd0, 1'b0, 8'd0, 1, 0);
        run_frame("T6", 3'd0, 8'd0, 1'b0, 8'd0, 0, 1);

        // T5 reset during row 1
        @(negedge HCLK);
        start = 1'b1; mode = 3'd0;
        @(negedge HCLK);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge HCLK);
            #1;
            if (mem_rd && mem_addr == 4'd0) found = 1;
        end
        chk("T5 reached_row1", found, 1);
        #2 HRESETn = 1'b0;
        #1;
        chk("T5 async_ctrl", {VSYNC, HSYNC, out_valid, mem_rd, busy, ctrl_done}, 0);
        chk("T5 async_data", {DATA_R, DATA_G, DATA_B}, 0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge HCLK);
            #1;
            if (mem_rd || out_valid || VSYNC || busy) stray++;
        end
        chk("T5 quiet_after_reset", stray, 0);
        run_frame("T5replay", 3'd0, 8'd0, 1'b0, 8'd0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule
